// File: rtl/axichannel_dep_replayer.sv
// Replays logged AXI channel beats in order, holding each entry until its
// dependency mask has been satisfied by runtime end events from other channels.
module axichannel_dep_replayer #(
   parameter int DATA_WIDTH       = 64,
   parameter int PIPE_DEPTH       = 2,
   parameter int FIFO_DEPTH       = 32,
   parameter int ALMFUL_THRESHOLD = 8,
   parameter int LOGE_CHANNEL_CNT = 8,
   parameter int TIMEOUT_CYCLES   = 0
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   input  logic                          logb_valid,
   input  logic [DATA_WIDTH-1:0]         logb_data,
   input  logic [LOGE_CHANNEL_CNT-1:0]   loge_valid,
   output logic                          in_almful,
   input  logic [LOGE_CHANNEL_CNT-1:0]   rt_loge_valid,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [$clog2(FIFO_DEPTH):0]   occupancy,
   output logic                          fifo_overflow,
   output logic                          dep_timeout
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = PW + 1;
   localparam int EW = 1 + DATA_WIDTH + LOGE_CHANNEL_CNT;
   localparam int BW = 1 + EW;
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, DEP, ISSUE} state_t;

   state_t                        state, state_next;
   logic [BW-1:0]                 beat_in, beat_p;
   logic                          almful_raw;
   logic [EW-1:0]                 mem [FIFO_DEPTH];
   logic [PW-1:0]                 wr_ptr, rd_ptr;
   logic [LOGE_CHANNEL_CNT-1:0]   seen;
   logic [TW-1:0]                 wd_cnt;
   logic                          wr_en, wr_acc, full, pop, remain, dep_ok;
   logic [EW-1:0]                 head;
   logic                          head_lv;
   logic [DATA_WIDTH-1:0]         head_data;
   logic [LOGE_CHANNEL_CNT-1:0]   head_mask;

   function automatic logic [TW-1:0] wd_inc(input logic [TW-1:0] c);
      if (int'(c) >= TIMEOUT_CYCLES) return c;
      return c + TW'(1);
   endfunction

   assign beat_in    = {in_valid, logb_valid, logb_data, loge_valid};
   assign almful_raw = (OW'(FIFO_DEPTH) - occupancy) <= OW'(ALMFUL_THRESHOLD);

   // Inbound beat and almful delay lines (stage 0 .. PIPE_DEPTH-1)
   generate
      if (PIPE_DEPTH == 0) begin : g_nopipe
         assign beat_p    = beat_in;
         assign in_almful = almful_raw;
      end else begin : g_pipe
         logic [BW-1:0]         beat_sr [PIPE_DEPTH];
         logic [PIPE_DEPTH-1:0] alm_sr;
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int i = 0; i < PIPE_DEPTH; i++) beat_sr[i] <= '0;
               alm_sr <= '0;
            end else begin
               beat_sr[0] <= beat_in;
               alm_sr[0]  <= almful_raw;
               for (int i = 1; i < PIPE_DEPTH; i++) begin
                  beat_sr[i] <= beat_sr[i-1];
                  alm_sr[i]  <= alm_sr[i-1];
               end
            end
         end
         assign beat_p    = beat_sr[PIPE_DEPTH-1];
         assign in_almful = alm_sr[PIPE_DEPTH-1];
      end
   endgenerate

   assign wr_en     = beat_p[BW-1];
   assign full      = (occupancy == OW'(FIFO_DEPTH));
   // A pop frees a slot in the same cycle, so a write into a full FIFO survives it
   assign wr_acc    = wr_en && (!full || pop);
   assign head      = mem[rd_ptr];
   assign head_lv   = head[EW-1];
   assign head_data = head[LOGE_CHANNEL_CNT +: DATA_WIDTH];
   assign head_mask = head[LOGE_CHANNEL_CNT-1:0];
   assign dep_ok    = (((seen | rt_loge_valid) & head_mask) == head_mask);
   // Pops only happen with an entry present, so anything beyond one entry or a new write remains
   assign remain    = (occupancy > OW'(1)) || wr_en;

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE:  if (occupancy != '0) state_next = DEP;
         DEP: begin
            if (dep_ok) begin
               if (head_lv) begin
                  state_next = ISSUE;
               end else begin
                  pop        = 1'b1;
                  state_next = remain ? DEP : IDLE;
               end
            end
         end
         ISSUE: begin
            if (out_ready) begin
               pop        = 1'b1;
               state_next = remain ? DEP : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= beat_p[EW-1:0];
   end

   // FIFO control, dependency tracking, issue register and watchdog
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         occupancy     <= '0;
         seen          <= '0;
         wd_cnt        <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         fifo_overflow <= 1'b0;
         dep_timeout   <= 1'b0;
      end else begin
         state     <= state_next;
         occupancy <= occupancy + OW'(wr_acc) - OW'(pop);
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         if (wr_en && full && !pop) fifo_overflow <= 1'b1;
         seen      <= (seen | rt_loge_valid) & ~(pop ? head_mask : '0);
         out_valid <= (state_next == ISSUE);
         if (state == DEP && state_next == ISSUE) out_data <= head_data;
         if (state == DEP) begin
            if (TIMEOUT_CYCLES > 0 && int'(wd_cnt) + 1 >= TIMEOUT_CYCLES) dep_timeout <= 1'b1;
            wd_cnt <= (state_next == DEP) ? wd_inc(wd_cnt) : '0;
         end else begin
            wd_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_axichannel_dep_replayer.sv
// Directed bench for axichannel_dep_replayer with an in-order payload scoreboard.
module tb_axichannel_dep_replayer;
   localparam int DW = 16;
   localparam int PD = 2;
   localparam int FD = 4;
   localparam int TH = 1;
   localparam int LC = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic          logb_valid = 1'b0;
   logic [DW-1:0] logb_data = '0;
   logic [LC-1:0] loge_valid = '0;
   logic          in_almful;
   logic [LC-1:0] rt_loge_valid = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic [$clog2(FD):0] occupancy;
   logic          fifo_overflow;
   logic          dep_timeout;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   axichannel_dep_replayer #(
      .DATA_WIDTH(DW), .PIPE_DEPTH(PD), .FIFO_DEPTH(FD),
      .ALMFUL_THRESHOLD(TH), .LOGE_CHANNEL_CNT(LC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .logb_valid(logb_valid),
      .logb_data(logb_data), .loge_valid(loge_valid), .in_almful(in_almful),
      .rt_loge_valid(rt_loge_valid), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .occupancy(occupancy), .fifo_overflow(fifo_overflow),
      .dep_timeout(dep_timeout)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic lv, input logic [DW-1:0] d, input logic [LC-1:0] m,
                       input bit push);
      in_valid   = 1'b1;
      logb_valid = lv;
      logb_data  = d;
      loge_valid = m;
      if (push) exp_q.push_back(d);
      tick();
      in_valid   = 1'b0;
      logb_valid = 1'b0;
      logb_data  = '0;
      loge_valid = '0;
   endtask

   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         chk("sb_expected_present", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) chk("sb_out_data", out_data, exp_q.pop_front());
      end
   end

   initial begin
      repeat (3) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_almful", in_almful, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_overflow", fifo_overflow, 0);
      chk("rst_timeout", dep_timeout, 0);
      chk("rst_out_data", out_data, 0);
      rstn = 1'b1;
      tick();

      // single beat, no dependency: out_valid for one cycle at t+5
      beat(1'b1, 16'h00A5, 4'b0000, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) tick();
         chk($sformatf("lat_valid_c%0d", k), out_valid, (k == 5));
         if (k == 3) chk("lat_occ_c3", occupancy, 1);
         if (k == 5) chk("lat_data_c5", out_data, 16'h00A5);
         if (k == 6) chk("lat_occ_c6", occupancy, 0);
      end

      // dependency mask 0101 released by two separate runtime events
      beat(1'b1, 16'h005A, 4'b0101, 1'b1);
      repeat (6) tick();
      chk("dep_wait_none", out_valid, 0);
      rt_loge_valid = 4'b0001;
      tick();
      rt_loge_valid = '0;
      repeat (3) tick();
      chk("dep_wait_bit0", out_valid, 0);
      rt_loge_valid = 4'b0100;
      chk("dep_same_cycle", out_valid, 0);
      tick();
      rt_loge_valid = '0;
      chk("dep_issue", out_valid, 1);
      chk("dep_issue_data", out_data, 16'h005A);
      tick();
      chk("dep_seen_cleared", dut.seen, 0);
      chk("dep_after_pop_valid", out_valid, 0);
      chk("dep_after_pop_occ", occupancy, 0);
      beat(1'b1, 16'h0077, 4'b0101, 1'b1);
      repeat (8) tick();
      chk("dep_reuse_blocked", out_valid, 0);
      rt_loge_valid = 4'b0101;
      tick();
      rt_loge_valid = '0;
      chk("dep_reuse_issue", out_valid, 1);
      tick();

      // logb_valid=0 beat is consumed silently
      beat(1'b0, 16'h0011, 4'b0000, 1'b0);
      beat(1'b1, 16'h0022, 4'b0000, 1'b1);
      repeat (10) tick();
      chk("skip_occ", occupancy, 0);
      chk("skip_sb_drained", exp_q.size(), 0);

      // fill with out_ready=0: almful, drop and overflow
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) beat(1'b1, DW'(16'h0030 + i), 4'b0000, i < 4);
      chk("fill_occ_3", occupancy, 3);
      chk("fill_almful_early", in_almful, 0);
      tick();
      chk("fill_occ_4", occupancy, 4);
      chk("fill_almful_delay", in_almful, 0);
      chk("fill_ovf_early", fifo_overflow, 0);
      tick();
      chk("fill_almful", in_almful, 1);
      chk("fill_overflow", fifo_overflow, 1);
      chk("fill_occ_kept", occupancy, 4);
      chk("fill_hold_valid", out_valid, 1);
      chk("fill_hold_data", out_data, 16'h0030);

      // reset while ISSUE is stalled
      rstn = 1'b0;
      #1;
      exp_q.delete();
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_occ", occupancy, 0);
      chk("rst_mid_ovf", fifo_overflow, 0);
      chk("rst_mid_almful", in_almful, 0);
      chk("rst_mid_data", out_data, 0);
      tick();
      tick();
      rstn = 1'b1;
      repeat (3) tick();
      chk("rst_rel_valid", out_valid, 0);
      chk("rst_rel_occ", occupancy, 0);

      // full FIFO: write coinciding with a handshake pop is accepted
      for (int i = 0; i < 4; i++) beat(1'b1, DW'(16'h0040 + i), 4'b0000, 1'b1);
      repeat (4) tick();
      chk("full_occ", occupancy, 4);
      chk("full_ovf", fifo_overflow, 0);
      chk("full_almful", in_almful, 1);
      chk("full_data", out_data, 16'h0040);
      beat(1'b1, 16'h0035, 4'b0000, 1'b1);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("simul_occ", occupancy, 4);
      chk("simul_ovf", fifo_overflow, 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, 16'h0041);
         tick();
      end
      out_ready = 1'b1;
      repeat (12) tick();
      chk("drain_sb", exp_q.size(), 0);
      chk("drain_occ", occupancy, 0);
      chk("drain_ovf", fifo_overflow, 0);

      // watchdog after 16 DEP cycles, entry still issues later
      chk("wd_pre", dep_timeout, 0);
      beat(1'b1, 16'h0066, 4'b1000, 1'b1);
      repeat (18) tick();
      chk("wd_c15", dep_timeout, 0);
      tick();
      chk("wd_c16", dep_timeout, 1);
      rt_loge_valid = 4'b1000;
      tick();
      rt_loge_valid = '0;
      chk("wd_issue_valid", out_valid, 1);
      chk("wd_issue_data", out_data, 16'h0066);
      tick();
      chk("wd_sticky", dep_timeout, 1);
      chk("wd_sb", exp_q.size(), 0);
      chk("wd_occ", occupancy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
